// File: rtl/rf_pkg.sv
// Shared widths, tag encoding and types for the renaming register file.
// TAG_FREE marks a register whose committed value is ready to use.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;
  localparam int NREG_DEF  = 32;
  localparam int TAG_FREE  = 0;

  function automatic int name_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int NAME_W_DEF = name_w(NREG_DEF);

  typedef logic [NAME_W_DEF-1:0] name_t;
  typedef logic [TAG_W_DEF-1:0]  tag_t;
  typedef logic [XLEN_DEF-1:0]   data_t;

endpackage

// File: rtl/rename_regfile_if.sv
// Dispatch, write-back and read bundle between the core and the rename register file.
// The core side is the master; the register file is the slave.
interface rename_regfile_if #(
  parameter int XLEN  = rf_pkg::XLEN_DEF,
  parameter int NREG  = rf_pkg::NREG_DEF,
  parameter int TAG_W = rf_pkg::TAG_W_DEF,
  parameter int NRD   = 2,
  parameter int NWB   = 2
);
  localparam int NAME_W = rf_pkg::name_w(NREG);

  logic                  flush;
  logic [NWB-1:0]        wb_en;
  logic [NWB*NAME_W-1:0] wb_name;
  logic [NWB*TAG_W-1:0]  wb_tag;
  logic [NWB*XLEN-1:0]   wb_data;
  logic                  dis_en;
  logic [NAME_W-1:0]     dis_name;
  logic [TAG_W-1:0]      dis_tag;
  logic [NRD*NAME_W-1:0] rd_name;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD*TAG_W-1:0]  rd_tag;

  modport master (
    output flush, wb_en, wb_name, wb_tag, wb_data,
    output dis_en, dis_name, dis_tag, rd_name,
    input  rd_data, rd_tag
  );

  modport slave (
    input  flush, wb_en, wb_name, wb_tag, wb_data,
    input  dis_en, dis_name, dis_tag, rd_name,
    output rd_data, rd_tag
  );

endinterface

// File: rtl/rf_read_bypass.sv
// One read port: forwards a same-cycle write-back whose tag resolves the register,
// otherwise returns the stored value and tag.
module rf_read_bypass
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NAME_W = NAME_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NWB    = 2
) (
  input  logic                  rst,
  input  logic [NAME_W-1:0]     rd_name,
  input  logic [NWB-1:0]        wb_en,
  input  logic [NWB*NAME_W-1:0] wb_name,
  input  logic [NWB*TAG_W-1:0]  wb_tag,
  input  logic [NWB*XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]       st_data,
  input  logic [TAG_W-1:0]      st_tag,
  output logic [XLEN-1:0]       rd_data,
  output logic [TAG_W-1:0]      rd_tag
);

  logic [NWB-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NWB; gi++) begin : g_hit
      assign hit[gi] = wb_en[gi]
                    && (wb_name[gi*NAME_W +: NAME_W] == rd_name)
                    && (wb_tag[gi*TAG_W +: TAG_W] == st_tag);
    end
  endgenerate

  // Ascending scan so the highest-index matching port is the one that sticks.
  always_comb begin
    rd_data = st_data;
    rd_tag  = st_tag;
    for (int k = 0; k < NWB; k++) begin
      if (hit[k]) begin
        rd_data = wb_data[k*XLEN +: XLEN];
        rd_tag  = TAG_W'(TAG_FREE);
      end
    end
    if (rst || (rd_name == '0)) begin
      rd_data = '0;
      rd_tag  = TAG_W'(TAG_FREE);
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file holding committed data plus the tag of each register's
// latest in-flight producer, with write-back bypass on reads and flush of all tags.
module rename_regfile
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = 2,
  parameter int NWB   = 2
) (
  input logic             clk,
  input logic             rst,
  rename_regfile_if.slave bus
);

  localparam int NAME_W = name_w(NREG);

  logic [XLEN-1:0]  data_reg [NREG];
  logic [TAG_W-1:0] tag_reg  [NREG];

  // Later non-blocking assignments win: higher write-back ports override lower ones,
  // dispatch overrides a write-back tag clear, and flush overrides everything on tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_reg[i] <= '0;
        tag_reg[i]  <= TAG_W'(TAG_FREE);
      end
    end else begin
      for (int k = 0; k < NWB; k++) begin
        if (bus.wb_en[k] && (bus.wb_name[k*NAME_W +: NAME_W] != '0)) begin
          data_reg[bus.wb_name[k*NAME_W +: NAME_W]] <= bus.wb_data[k*XLEN +: XLEN];
          if (tag_reg[bus.wb_name[k*NAME_W +: NAME_W]] == bus.wb_tag[k*TAG_W +: TAG_W])
            tag_reg[bus.wb_name[k*NAME_W +: NAME_W]] <= TAG_W'(TAG_FREE);
          else
            tag_reg[bus.wb_name[k*NAME_W +: NAME_W]] <= tag_reg[bus.wb_name[k*NAME_W +: NAME_W]];
        end
      end
      if (bus.dis_en && (bus.dis_name != '0) && !bus.flush)
        tag_reg[bus.dis_name] <= bus.dis_tag;
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++)
          tag_reg[i] <= TAG_W'(TAG_FREE);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [NAME_W-1:0] name;
      logic [XLEN-1:0]   rd_data_w;
      logic [TAG_W-1:0]  rd_tag_w;

      assign name = bus.rd_name[gi*NAME_W +: NAME_W];

      rf_read_bypass #(
        .XLEN  (XLEN),
        .NAME_W(NAME_W),
        .TAG_W (TAG_W),
        .NWB   (NWB)
      ) u_bypass (
        .rst    (rst),
        .rd_name(name),
        .wb_en  (bus.wb_en),
        .wb_name(bus.wb_name),
        .wb_tag (bus.wb_tag),
        .wb_data(bus.wb_data),
        .st_data(data_reg[name]),
        .st_tag (tag_reg[name]),
        .rd_data(rd_data_w),
        .rd_tag (rd_tag_w)
      );

      assign bus.rd_data[gi*XLEN +: XLEN]  = rd_data_w;
      assign bus.rd_tag[gi*TAG_W +: TAG_W] = rd_tag_w;
    end
  endgenerate

endmodule
